// File: rtl/cmul_seq.sv
// cmul_seq: operand sequencer for a shared external 16x16 unsigned multiplier.
// Takes one signed complex sample and one signed Q1.15 twiddle per
// transaction, pushes the four real partial products through the multiplier
// in sign-magnitude form (one per cycle), accumulates them, rounds half
// toward +inf, shifts right by SHIFT and returns the signed complex product.
//
// Build option: define CMUL_SAT_EN to saturate the shifted result to OUT_W
// bits; otherwise the result wraps (low OUT_W bits kept). Rounding is the
// same in both builds.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake
//   a_re, a_im          signed sample
//   w_re, w_im          signed Q1.15 twiddle
//   mul_a, mul_b        registered magnitudes to the multiplier
//   mul_p               unsigned product from the multiplier (combinational)
//   out_valid/out_ready result handshake
//   out_re, out_im      signed OUT_W-bit result
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// P0    | multiplier holds |a_re|*|w_re|
// P1    | multiplier holds |a_im|*|w_im|
// P2    | multiplier holds |a_re|*|w_im|
// P3    | multiplier holds |a_im|*|w_re|, result formed on exit
// DONE  | result presented, in_ready follows out_ready

module cmul_seq #(
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       a_re,
   input  logic [15:0]       a_im,
   input  logic [15:0]       w_re,
   input  logic [15:0]       w_im,
   output logic [15:0]       mul_a,
   output logic [15:0]       mul_b,
   input  logic [31:0]       mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_re,
   output logic [OUT_W-1:0]  out_im
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P0   = 3'd1,
      P1   = 3'd2,
      P2   = 3'd3,
      P3   = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic signed [32:0] RND     = 33'sd1 <<< (SHIFT - 1);
   localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
   localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_W - 1));

   state_t                   state_q, state_d;
   logic [15:0]              a_re_q, a_re_d;
   logic [15:0]              a_im_q, a_im_d;
   logic [15:0]              w_re_q, w_re_d;
   logic [15:0]              w_im_q, w_im_d;
   logic [15:0]              mul_a_q, mul_a_d;
   logic [15:0]              mul_b_q, mul_b_d;
   logic                     neg_q, neg_d;
   logic signed [32:0]       acc_re_q, acc_re_d;
   logic signed [32:0]       acc_im_q, acc_im_d;
   logic                     out_valid_q, out_valid_d;
   logic [OUT_W-1:0]         out_re_q, out_re_d;
   logic [OUT_W-1:0]         out_im_q, out_im_d;
   logic signed [32:0]       prod;
   logic signed [32:0]       acc_im_fin;

   // |-32768| = 32768 still fits the unsigned 16-bit operand.
   function automatic logic [15:0] mag16(input logic [15:0] x);
      mag16 = x[15] ? (~x + 16'd1) : x;
   endfunction

   function automatic logic [OUT_W-1:0] reduce(input logic signed [32:0] acc);
      logic signed [32:0] r;
      r = (acc + RND) >>> SHIFT;
`ifdef CMUL_SAT_EN
      if (r > SAT_MAX) begin
         r = SAT_MAX;
      end else if (r < SAT_MIN) begin
         r = SAT_MIN;
      end
`endif
      reduce = r[OUT_W-1:0];
   endfunction

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

   // neg_q was registered together with the magnitudes now on mul_a/mul_b.
   assign prod       = neg_q ? (33'sd0 - $signed({1'b0, mul_p})) : $signed({1'b0, mul_p});
   assign acc_im_fin = acc_im_q + prod;

   always_comb begin
      state_d     = state_q;
      a_re_d      = a_re_q;
      a_im_d      = a_im_q;
      w_re_d      = w_re_q;
      w_im_d      = w_im_q;
      mul_a_d     = 16'd0;
      mul_b_d     = 16'd0;
      neg_d       = 1'b0;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      out_valid_d = out_valid_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_re_d  = a_re;
               a_im_d  = a_im;
               w_re_d  = w_re;
               w_im_d  = w_im;
               mul_a_d = mag16(a_re);
               mul_b_d = mag16(w_re);
               neg_d   = a_re[15] ^ w_re[15];
               state_d = P0;
            end
         end
         P0: begin
            acc_re_d = prod;
            mul_a_d  = mag16(a_im_q);
            mul_b_d  = mag16(w_im_q);
            neg_d    = a_im_q[15] ^ w_im_q[15];
            state_d  = P1;
         end
         P1: begin
            acc_re_d = acc_re_q - prod;
            mul_a_d  = mag16(a_re_q);
            mul_b_d  = mag16(w_im_q);
            neg_d    = a_re_q[15] ^ w_im_q[15];
            state_d  = P2;
         end
         P2: begin
            acc_im_d = prod;
            mul_a_d  = mag16(a_im_q);
            mul_b_d  = mag16(w_re_q);
            neg_d    = a_im_q[15] ^ w_re_q[15];
            state_d  = P3;
         end
         P3: begin
            acc_im_d    = acc_im_fin;
            out_re_d    = reduce(acc_re_q);
            out_im_d    = reduce(acc_im_fin);
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (in_valid) begin
                  a_re_d  = a_re;
                  a_im_d  = a_im;
                  w_re_d  = w_re;
                  w_im_d  = w_im;
                  mul_a_d = mag16(a_re);
                  mul_b_d = mag16(w_re);
                  neg_d   = a_re[15] ^ w_re[15];
                  state_d = P0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_re_q      <= '0;
         a_im_q      <= '0;
         w_re_q      <= '0;
         w_im_q      <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         neg_q       <= 1'b0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         state_q     <= state_d;
         a_re_q      <= a_re_d;
         a_im_q      <= a_im_d;
         w_re_q      <= w_re_d;
         w_im_q      <= w_im_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         neg_q       <= neg_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;

endmodule

// File: tb/tb_cmul_seq.sv
// Testbench for cmul_seq: directed vectors with literal expectations plus a
// complex-multiply reference model checked on every presented result.
module tb_cmul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;
   logic [15:0] mul_a, mul_b;
   logic [31:0] mul_p;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_re, out_im;

   int  n_pass  = 0;
   int  n_total = 0;
   int  n_pop   = 0;
   bit  rand_mode = 1'b0;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   // The external multiplier.
   assign mul_p = {16'd0, mul_a} * {16'd0, mul_b};

   cmul_seq #(.OUT_W(16), .SHIFT(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_re      (a_re),
      .a_im      (a_im),
      .w_re      (w_re),
      .w_im      (w_im),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
   endtask

   // Reference: exact complex product, round half up, >>15, saturate or wrap.
   function automatic logic [15:0] reduce_m(input longint acc);
      longint r;
      r = (acc + 64'sd16384) >>> 15;
`ifdef CMUL_SAT_EN
      if (r > 64'sd32767) r = 64'sd32767;
      else if (r < -64'sd32768) r = -64'sd32768;
`endif
      return r[15:0];
   endfunction

   function automatic exp_t model(input logic signed [15:0] ar, input logic signed [15:0] ai,
                                  input logic signed [15:0] wr, input logic signed [15:0] wi);
      exp_t e;
      longint pr, pi;
      pr = longint'(ar) * longint'(wr) - longint'(ai) * longint'(wi);
      pi = longint'(ar) * longint'(wi) + longint'(ai) * longint'(wr);
      e.re = reduce_m(pr);
      e.im = reduce_m(pi);
      return e;
   endfunction

   // Compare process: every cycle a result is presented it must match the
   // oldest outstanding transaction; results leave on out_ready.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out", 16'(out_valid), 16'd0);
            end else begin
               check("out_re", out_re, q[0].re);
               check("out_im", out_im, q[0].im);
               if (out_ready) begin
                  void'(q.pop_front());
                  n_pop++;
               end
            end
         end
         if (in_valid && in_ready)
            q.push_back(model(a_re, a_im, w_re, w_im));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Returns one time unit after the acceptance edge (state P0).
   task automatic send(input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] wr, input logic [15:0] wi);
      bit ok;
      ok = 1'b0;
      a_re = ar; a_im = ai; w_re = wr; w_im = wi;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         step();
      end
      in_valid = 1'b0;
      if (!ok) check("accept_timeout", 16'd0, 16'd1);
   endtask

   // Edges from acceptance edge (inclusive) until out_valid is seen.
   task automatic wait_out(output int edges);
      edges = 1;
      for (int i = 0; i < 200 && !out_valid; i++) begin
         step();
         edges++;
      end
      if (!out_valid) check("out_valid_timeout", 16'd0, 16'd1);
   endtask

   task automatic run_one(input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] wr, input logic [15:0] wi,
                          input string name, input logic [15:0] exp_re, input logic [15:0] exp_im);
      int e;
      send(ar, ai, wr, wi);
      wait_out(e);
      check({name, "_latency"}, 16'(e), 16'd5);
      check({name, "_re"}, out_re, exp_re);
      check({name, "_im"}, out_im, exp_im);
      step();
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 9))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'h0000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      logic [15:0] hold_re, hold_im;
      int n0;
      bit saw;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 16'(in_ready), 16'd1);
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_out_re", out_re, 16'd0);
      check("rst_out_im", out_im, 16'd0);
      check("rst_mul_a", mul_a, 16'd0);
      check("rst_mul_b", mul_b, 16'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      // a = 16384, w = j*32767: operand sequence and 5-edge latency.
      send(16'd16384, 16'd0, 16'd0, 16'd32767);
      check("p0_mul_a", mul_a, 16'd16384);
      check("p0_mul_b", mul_b, 16'd0);
      check("p0_out_valid", 16'(out_valid), 16'd0);
      step();
      check("p1_mul_a", mul_a, 16'd0);
      check("p1_mul_b", mul_b, 16'd32767);
      step();
      check("p2_mul_a", mul_a, 16'd16384);
      check("p2_mul_b", mul_b, 16'd32767);
      step();
      check("p3_mul_a", mul_a, 16'd0);
      check("p3_mul_b", mul_b, 16'd0);
      check("p3_out_valid", 16'(out_valid), 16'd0);
      step();
      check("done_out_valid", 16'(out_valid), 16'd1);
      check("done_mul_a", mul_a, 16'd0);
      check("t1_re", out_re, 16'd0);
      check("t1_im", out_im, 16'd16384);
      step();
      check("idle_in_ready", 16'(in_ready), 16'd1);

      // Full-scale corner: (-1)*(-1) in Q1.15 is +1.0.
`ifdef CMUL_SAT_EN
      run_one(16'h8000, 16'd0, 16'h8000, 16'd0, "fullscale", 16'd32767, 16'd0);
`else
      run_one(16'h8000, 16'd0, 16'h8000, 16'd0, "fullscale", 16'h8000, 16'd0);
`endif

      // Rounding half toward +inf.
      run_one(16'hFFFF, 16'd0, 16'd16384, 16'd0, "rnd_m1", 16'd0, 16'd0);
      run_one(16'hFFFD, 16'd0, 16'd16384, 16'd0, "rnd_m3", 16'hFFFF, 16'd0);
      run_one(16'd3, 16'd0, 16'd16384, 16'd0, "rnd_p3", 16'd2, 16'd0);

      // Backpressure: (1000+2000j)*(0.5-0.5j) = 1500+500j.
      out_ready = 1'b0;
      send(16'd1000, 16'd2000, 16'd16384, 16'hC000);
      wait_out(e);
      check("bp_latency", 16'(e), 16'd5);
      check("bp_re", out_re, 16'd1500);
      check("bp_im", out_im, 16'd500);
      hold_re = out_re;
      hold_im = out_im;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold_valid", 16'(out_valid), 16'd1);
         check("bp_hold_re", out_re, hold_re);
         check("bp_hold_im", out_im, hold_im);
         check("bp_in_ready", 16'(in_ready), 16'd0);
      end
      // Release together with a new transaction: (-100+50j)*(32767/32768).
      out_ready = 1'b1;
      a_re = 16'hFF9C; a_im = 16'd50; w_re = 16'd32767; w_im = 16'd0;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 16'(in_ready), 16'd1);
      step();
      in_valid = 1'b0;
      check("b2b_p0_out_valid", 16'(out_valid), 16'd0);
      wait_out(e);
      check("b2b_latency", 16'(e), 16'd5);
      check("b2b_re", out_re, 16'hFF9C);
      check("b2b_im", out_im, 16'd50);
      step();

      // Reset in P2 discards the transaction.
      send(16'd1234, 16'hFDC9, 16'd2000, 16'hF448);
      step();
      step();
      check("p2_pre_rst_mul_a", mul_a, 16'd1234);
      check("p2_pre_rst_mul_b", mul_b, 16'd3000);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 16'(out_valid), 16'd0);
      check("arst_in_ready", 16'(in_ready), 16'd1);
      check("arst_mul_a", mul_a, 16'd0);
      check("arst_mul_b", mul_b, 16'd0);
      step();
      step();
      rst_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) saw = 1'b1;
      end
      check("no_out_after_rst", 16'(saw), 16'd0);

      // Random traffic.
      n0 = n_pop;
      rand_mode = 1'b1;
      for (int t = 0; t < 1000; t++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) step();
         send(rnd16(), rnd16(), rnd16(), rnd16());
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) step();
      check("queue_drained", 16'(q.size()), 16'd0);
      check("result_count", 16'(n_pop - n0), 16'd1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
